cla_adder: RTL and testbench
============================

CLA_ADDER -- requirements
Module: cla_adder

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; SHALL be a multiple of 4, range 4..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 A  input  WIDTH  operand A, unsigned or two's complement.
REQ-005 B  input  WIDTH  operand B, unsigned or two's complement.
REQ-006 CIN  input  1  carry in to bit 0.
REQ-007 SUM  output  WIDTH  registered result, (A + B + CIN) mod 2^WIDTH.
REQ-008 COUT  output  1  registered carry out of the MSB.
REQ-009 OVFL  output  1  registered two's-complement overflow flag.

Function
REQ-010 Per bit: generate g[i] = A[i] & B[i]; propagate p[i] = A[i] ^ B[i]; SUM[i] = p[i] ^ c[i]; c[0] = CIN.
REQ-011 Carries inside each 4-bit group SHALL be computed by lookahead equations from g, p and group carry-in, with no ripple chain between bits.
REQ-012 Each 4-bit group SHALL produce group generate G and group propagate P.
REQ-013 Group carry-ins SHALL come from a second-level lookahead unit over (G, P) of all groups; groups SHALL NOT ripple into each other.
REQ-014 COUT = carry out of bit WIDTH-1.
REQ-015 OVFL = c[WIDTH-1] XOR COUT.
REQ-016 OVFL is therefore 1 exactly when A and B have equal sign bits and SUM's sign bit differs.
REQ-017 Latency: with CLA_IN_REG_EN undefined, outputs SHALL reflect inputs sampled at edge N after edge N (1 cycle). No handshake; a new operation SHALL be accepted every cycle.
REQ-018 Full wrap-around: all-ones + 1 SHALL give SUM = 0 and COUT = 1.
REQ-019 CIN = 1 with all-ones + all-ones SHALL give SUM = all-ones and COUT = 1.
REQ-020 Result SHALL be bit-exact to the behavioural expression {COUT,SUM} = A + B + CIN for every input combination.

Reset
REQ-021 While rst is high at a rising edge, SUM, COUT and OVFL SHALL be 0 after that edge, and any pipeline registers SHALL also clear to 0.
REQ-022 Reset SHALL take priority over any operation in flight; an operation sampled on a reset edge SHALL be discarded.
REQ-023 The first valid result SHALL appear for inputs sampled on the first edge with rst low.
REQ-024 rst SHALL have no asynchronous effect.

Configuration
REQ-025 Macro CLA_IN_REG_EN: when defined, A, B and CIN SHALL be registered before the adder, and total latency SHALL be 2 cycles.
REQ-026 When CLA_IN_REG_EN is defined, input registers SHALL also reset to 0.
REQ-027 When CLA_IN_REG_EN is undefined, there are no input registers and latency SHALL be 1 cycle.
REQ-028 Function SHALL be identical in both builds apart from latency.

Verification
REQ-029 Unsigned wrap: A=4'hF, B=4'h1, CIN=0 -> SUM=0, COUT=1, OVFL=0.
REQ-030 Positive overflow: A=7, B=1, CIN=0 -> SUM=8, COUT=0, OVFL=1.
REQ-031 Positive overflow with carry in: A=5, B=3, CIN=1 -> SUM=9, COUT=0, OVFL=1.
REQ-032 Negative overflow: A=8, B=8, CIN=0 -> SUM=0, COUT=1, OVFL=1; and A=4'hF, B=4'hF, CIN=1 -> SUM=4'hF, COUT=1, OVFL=0.
REQ-033 Exhaustive and back-to-back: all 512 (A,B,CIN) combinations at WIDTH=4, one per cycle, each checked against A+B+CIN after the configured latency; repeat random at WIDTH=16.
REQ-034 Reset mid-stream: assert rst for 1 cycle during back-to-back operations -> outputs 0 the cycle after the reset edge, the discarded operation never appears, and the next result is correct.

Source files
------------

// File: rtl/cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla_adder
//  Description : Two-level carry-lookahead adder with registered outputs.
//                The operand is split into 4-bit groups. Each group computes
//                its internal carries with lookahead equations and also
//                produces a group generate/propagate pair. A second-level
//                lookahead unit turns those pairs into the group carry-ins,
//                so no carry ripples between bits or between groups.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH : operand width, a multiple of 4 in the range 4..32
//  Ports
//    clk   in   1      clock, rising edge
//    rst   in   1      synchronous active-high reset
//    A     in   WIDTH  operand A (unsigned or two's complement)
//    B     in   WIDTH  operand B (unsigned or two's complement)
//    CIN   in   1      carry into bit 0
//    SUM   out  WIDTH  registered (A + B + CIN) mod 2^WIDTH
//    COUT  out  1      registered carry out of the MSB
//    OVFL  out  1      registered two's-complement overflow
//  Build option
//    CLA_IN_REG_EN : when defined, A/B/CIN are registered before the adder
//                    and total latency becomes 2 cycles (default: 1 cycle).
// ============================================================================
module cla_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVFL
);

  localparam int c_num_groups = WIDTH / 4;

  // Operands as seen by the adder core (optionally registered).
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;

`ifdef CLA_IN_REG_EN
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
    end else begin
      r_a   <= A;
      r_b   <= B;
      r_cin <= CIN;
    end
  end

  assign w_a   = r_a;
  assign w_b   = r_b;
  assign w_cin = r_cin;
`else
  assign w_a   = A;
  assign w_b   = B;
  assign w_cin = CIN;
`endif

  // Bit-level generate / propagate.
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;

  assign w_g = w_a & w_b;
  assign w_p = w_a ^ w_b;

  // Group-level generate / propagate and group carry-ins.
  // w_grp_cin[c_num_groups] is the carry out of the whole word.
  logic [c_num_groups-1:0] w_grp_g;
  logic [c_num_groups-1:0] w_grp_p;
  logic [c_num_groups:0]   w_grp_cin;

  // Per-bit carry into each bit position.
  logic [WIDTH-1:0] w_carry;

  generate
    for (genvar gi = 0; gi < c_num_groups; gi++) begin : g_group
      logic [3:0] w_lg;
      logic [3:0] w_lp;
      logic       w_ci;

      assign w_lg = w_g[4*gi +: 4];
      assign w_lp = w_p[4*gi +: 4];
      assign w_ci = w_grp_cin[gi];

      // Flat sum-of-products carries: every carry depends only on g, p and
      // the group carry-in, never on a neighbouring carry.
      assign w_carry[4*gi]     = w_ci;
      assign w_carry[4*gi + 1] = w_lg[0]
                               | (w_lp[0] & w_ci);
      assign w_carry[4*gi + 2] = w_lg[1]
                               | (w_lp[1] & w_lg[0])
                               | (w_lp[1] & w_lp[0] & w_ci);
      assign w_carry[4*gi + 3] = w_lg[2]
                               | (w_lp[2] & w_lg[1])
                               | (w_lp[2] & w_lp[1] & w_lg[0])
                               | (w_lp[2] & w_lp[1] & w_lp[0] & w_ci);

      assign w_grp_g[gi] = w_lg[3]
                         | (w_lp[3] & w_lg[2])
                         | (w_lp[3] & w_lp[2] & w_lg[1])
                         | (w_lp[3] & w_lp[2] & w_lp[1] & w_lg[0]);
      assign w_grp_p[gi] = &w_lp;
    end
  endgenerate

  // Second-level lookahead. For group j the carry-in is
  //   OR over k<j of ( G[k] & P[k+1] & ... & P[j-1] )  |  CIN & P[0] & ... & P[j-1]
  // The loops only unroll into that flat two-level expression.
  always_comb begin
    logic acc;
    logic term;
    w_grp_cin = '0;
    acc       = 1'b0;
    term      = 1'b0;
    for (int j = 0; j <= c_num_groups; j++) begin
      term = w_cin;
      for (int m = 0; m < j; m++) begin
        term = term & w_grp_p[m];
      end
      acc = term;
      for (int k = 0; k < j; k++) begin
        term = w_grp_g[k];
        for (int m = k + 1; m < j; m++) begin
          term = term & w_grp_p[m];
        end
        acc = acc | term;
      end
      w_grp_cin[j] = acc;
    end
  end

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovfl;

  assign w_sum  = w_p ^ w_carry;
  assign w_cout = w_grp_cin[c_num_groups];
  // Overflow: carry into the sign bit differs from carry out of it.
  assign w_ovfl = w_carry[WIDTH-1] ^ w_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      SUM  <= '0;
      COUT <= 1'b0;
      OVFL <= 1'b0;
    end else begin
      SUM  <= w_sum;
      COUT <= w_cout;
      OVFL <= w_ovfl;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_adder
//  Description : Self-checking bench for cla_adder. Drives a WIDTH=4 and a
//                WIDTH=16 instance in parallel, one operation per cycle, and
//                compares each against a delay line of results computed
//                with plain integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_adder;

`ifdef CLA_IN_REG_EN
  localparam int c_lat = 2;
`else
  localparam int c_lat = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        cin4 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;
  logic [3:0]  sum4;
  logic        cout4, ovfl4;
  logic [15:0] sum16;
  logic        cout16, ovfl16;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {ovfl, cout, sum} per pipeline stage; index c_lat-1 is visible.
  logic [5:0]  exp4  [0:1];
  logic [17:0] exp16 [0:1];

  always #5 clk = ~clk;

  cla_adder #(.WIDTH(4)) u_dut4 (
    .clk (clk), .rst (rst), .A (a4), .B (b4), .CIN (cin4),
    .SUM (sum4), .COUT (cout4), .OVFL (ovfl4)
  );

  cla_adder #(.WIDTH(16)) u_dut16 (
    .clk (clk), .rst (rst), .A (a16), .B (b16), .CIN (cin16),
    .SUM (sum16), .COUT (cout16), .OVFL (ovfl16)
  );

  function automatic logic [5:0] ref4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    int s;
    logic sgn;
    s   = int'(a) + int'(b) + int'(cin);
    // Signed overflow: operands agree in sign, result sign differs.
    sgn = s[3];
    return {(a[3] == b[3]) && (sgn != a[3]), s[4], s[3:0]};
  endfunction

  function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    int s;
    logic sgn;
    s   = int'(a) + int'(b) + int'(cin);
    sgn = s[15];
    return {(a[15] == b[15]) && (sgn != a[15]), s[16], s[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model with the values present at the edge,
  // then compare both instances shortly after the edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst) begin
      exp4[0]  = '0; exp4[1]  = '0;
      exp16[0] = '0; exp16[1] = '0;
    end else begin
      exp4[1]  = exp4[0];
      exp16[1] = exp16[0];
      exp4[0]  = ref4(a4, b4, cin4);
      exp16[0] = ref16(a16, b16, cin16);
    end
    #1;
    check({tag, "_w4"},  {58'd0, ovfl4, cout4, sum4},    {58'd0, exp4[c_lat-1]});
    check({tag, "_w16"}, {46'd0, ovfl16, cout16, sum16}, {46'd0, exp16[c_lat-1]});
  endtask

  task automatic rand16();
    a16   = 16'($urandom);
    b16   = 16'($urandom);
    cin16 = 1'($urandom);
  endtask

  // Hold a vector for the full latency, then compare with literal values.
  task automatic directed(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic cin, input logic [3:0] s, input logic co,
                          input logic ov);
    a4 = a; b4 = b; cin4 = cin;
    for (int i = 0; i < c_lat; i++) begin
      rand16();
      cycle("dir_model");
    end
    check(tag, {58'd0, ovfl4, cout4, sum4}, {58'd0, ov, co, s});
  endtask

  initial begin
    exp4[0]  = '0; exp4[1]  = '0;
    exp16[0] = '0; exp16[1] = '0;

    // Reset state.
    rst = 1'b1;
    cycle("reset");
    cycle("reset");
    check("reset_zero", {58'd0, ovfl4, cout4, sum4}, 64'd0);
    rst = 1'b0;

    // Corner vectors.
    directed("unsigned_wrap",  4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    directed("pos_ovfl",       4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
    directed("pos_ovfl_cin",   4'h5, 4'h3, 1'b1, 4'h9, 1'b0, 1'b1);
    directed("neg_ovfl",       4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1);
    directed("ones_ones_cin",  4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);

    // 16-bit corners, held for the latency then checked literally.
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0;
    for (int i = 0; i < c_lat; i++) cycle("w16_wrap_model");
    check("w16_wrap", {46'd0, ovfl16, cout16, sum16}, {46'd0, 2'b01, 16'h0000});
    a16 = 16'h7FFF; b16 = 16'h0000; cin16 = 1'b1;
    for (int i = 0; i < c_lat; i++) cycle("w16_povf_model");
    check("w16_pos_ovfl", {46'd0, ovfl16, cout16, sum16}, {46'd0, 2'b10, 16'h8000});

    // Exhaustive 4-bit sweep back-to-back, random 16-bit alongside.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c);
          rand16();
          cycle("exh");
        end
      end
    end

    // Random stream with a single-cycle reset in the middle.
    for (int i = 0; i < 200; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      rand16();
      rst = (i == 100);
      cycle("rand");
      if (i == 100) begin
        check("mid_reset_w4",  {58'd0, ovfl4, cout4, sum4},    64'd0);
        check("mid_reset_w16", {46'd0, ovfl16, cout16, sum16}, 64'd0);
      end
    end
    rst = 1'b0;

    for (int i = 0; i < c_lat; i++) begin
      rand16();
      cycle("drain");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
